// File: rtl/alsu_cmd_seq.sv
// Command sequencer for the ALSU: buffers tagged commands, issues at most one per cycle onto
// the registered ALSU pins, and returns each captured result with its tag and error flag.
module alsu_cmd_seq #(
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4,
  parameter int TAG_W     = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_a,
  input  logic [2:0]       cmd_b,
  input  logic [2:0]       cmd_opcode,
  input  logic [6:0]       cmd_ctrl,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [2:0]       alsu_A,
  output logic [2:0]       alsu_B,
  output logic [2:0]       alsu_opcode,
  output logic             alsu_cin,
  output logic             alsu_serial_in,
  output logic             alsu_red_op_A,
  output logic             alsu_red_op_B,
  output logic             alsu_bypass_A,
  output logic             alsu_bypass_B,
  output logic             alsu_direction,
  input  logic [5:0]       alsu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [5:0]       rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err
);
  localparam int CAW    = $clog2(CMD_DEPTH);
  localparam int RAW    = $clog2(RSP_DEPTH);
  localparam int STAGES = 3;
  localparam int UW     = RAW + 2;

  typedef struct packed {
    logic [2:0]       a;
    logic [2:0]       b;
    logic [2:0]       op;
    logic [6:0]       ctrl;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  typedef struct packed {
    logic [5:0]       data;
    logic [TAG_W-1:0] tag;
    logic             err;
  } rsp_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             err;
  } trk_t;

  typedef struct packed {
    logic [2:0] a;
    logic [2:0] b;
    logic [2:0] op;
    logic [6:0] ctrl;
  } pin_t;

  cmd_t             cmd_mem_q [CMD_DEPTH];
  rsp_t             rsp_mem_q [RSP_DEPTH];
  logic [CAW-1:0]   cmd_wr_q, cmd_wr_d, cmd_rd_q, cmd_rd_d;
  logic [CAW:0]     cmd_cnt_q, cmd_cnt_d;
  logic [RAW-1:0]   rsp_wr_q, rsp_wr_d, rsp_rd_q, rsp_rd_d;
  logic [RAW:0]     rsp_cnt_q, rsp_cnt_d;
  logic [STAGES:1]  vld_pipe_q, vld_pipe_d;
  trk_t [STAGES:1]  trk_q, trk_d;
  pin_t             pin_q, pin_d;
  logic             ready_en_q, ready_en_d;

  cmd_t        cmd_in, cmd_head;
  rsp_t        rsp_in, rsp_head;
  logic [UW-1:0] used;
  logic        push, issue, cap, pop, err_issue;

  assign cmd_ready = ready_en_q && (cmd_cnt_q != (CAW+1)'(CMD_DEPTH));
  assign rsp_valid = (rsp_cnt_q != '0);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = rsp_valid && rsp_ready;
  assign cap       = vld_pipe_q[STAGES];
  assign cmd_in    = '{a: cmd_a, b: cmd_b, op: cmd_opcode, ctrl: cmd_ctrl, tag: cmd_tag};
  assign cmd_head  = cmd_mem_q[cmd_rd_q];
  assign rsp_head  = rsp_mem_q[rsp_rd_q];
  assign rsp_in    = '{data: alsu_out, tag: trk_q[STAGES].tag, err: trk_q[STAGES].err};

  // Credits: every issued command must already own a response slot, since the ALSU cannot stall.
  always_comb begin
    used = UW'(rsp_cnt_q);
    for (int s = 1; s <= STAGES; s++) used = used + UW'(vld_pipe_q[s]);
  end

  assign issue = (cmd_cnt_q != '0) && (used < UW'(RSP_DEPTH));

  // ctrl = {bypass_B, bypass_A, red_op_B, red_op_A, direction, serial_in, cin}
  assign err_issue = !cmd_head.ctrl[5] && !cmd_head.ctrl[6] &&
                     (((cmd_head.ctrl[3] | cmd_head.ctrl[4]) && (cmd_head.op[1] | cmd_head.op[2])) ||
                      (cmd_head.op[1] && cmd_head.op[2]));

  always_comb begin
    cmd_wr_d   = push  ? cmd_wr_q + CAW'(1) : cmd_wr_q;
    cmd_rd_d   = issue ? cmd_rd_q + CAW'(1) : cmd_rd_q;
    cmd_cnt_d  = cmd_cnt_q + (CAW+1)'(push) - (CAW+1)'(issue);
    rsp_wr_d   = cap ? rsp_wr_q + RAW'(1) : rsp_wr_q;
    rsp_rd_d   = pop ? rsp_rd_q + RAW'(1) : rsp_rd_q;
    rsp_cnt_d  = rsp_cnt_q + (RAW+1)'(cap) - (RAW+1)'(pop);
    ready_en_d = 1'b1;
    // Idle cycles drive all-zero so the ALSU output settles to 0 behind them.
    pin_d      = '0;
    if (issue) pin_d = '{a: cmd_head.a, b: cmd_head.b, op: cmd_head.op, ctrl: cmd_head.ctrl};
    vld_pipe_d = {vld_pipe_q[STAGES-1:1], issue};
    trk_d      = {trk_q[STAGES-1:1], trk_t'{tag: cmd_head.tag, err: err_issue}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_wr_q   <= '0;
      cmd_rd_q   <= '0;
      cmd_cnt_q  <= '0;
      rsp_wr_q   <= '0;
      rsp_rd_q   <= '0;
      rsp_cnt_q  <= '0;
      vld_pipe_q <= '0;
      trk_q      <= '0;
      pin_q      <= '0;
      ready_en_q <= 1'b0;
    end else begin
      cmd_wr_q   <= cmd_wr_d;
      cmd_rd_q   <= cmd_rd_d;
      cmd_cnt_q  <= cmd_cnt_d;
      rsp_wr_q   <= rsp_wr_d;
      rsp_rd_q   <= rsp_rd_d;
      rsp_cnt_q  <= rsp_cnt_d;
      vld_pipe_q <= vld_pipe_d;
      trk_q      <= trk_d;
      pin_q      <= pin_d;
      ready_en_q <= ready_en_d;
    end
  end

  // Storage needs no reset: counts gate every read and the response outputs are masked.
  always_ff @(posedge clk) begin
    if (push) cmd_mem_q[cmd_wr_q] <= cmd_in;
    if (cap)  rsp_mem_q[rsp_wr_q] <= rsp_in;
  end

  assign alsu_A         = pin_q.a;
  assign alsu_B         = pin_q.b;
  assign alsu_opcode    = pin_q.op;
  assign alsu_cin       = pin_q.ctrl[0];
  assign alsu_serial_in = pin_q.ctrl[1];
  assign alsu_direction = pin_q.ctrl[2];
  assign alsu_red_op_A  = pin_q.ctrl[3];
  assign alsu_red_op_B  = pin_q.ctrl[4];
  assign alsu_bypass_A  = pin_q.ctrl[5];
  assign alsu_bypass_B  = pin_q.ctrl[6];

  assign rsp_data = rsp_valid ? rsp_head.data : '0;
  assign rsp_tag  = rsp_valid ? rsp_head.tag  : '0;
  assign rsp_err  = rsp_valid && rsp_head.err;

endmodule

// File: tb/tb_alsu_cmd_seq.sv
// Directed bench for alsu_cmd_seq with a behavioural ALSU (registered inputs and output)
// closing the loop from the alsu_* pins back to alsu_out.
module tb_alsu_cmd_seq;
  logic       clk, rst_n;
  logic       cmd_valid, cmd_ready;
  logic [2:0] cmd_a, cmd_b, cmd_opcode;
  logic [6:0] cmd_ctrl;
  logic [1:0] cmd_tag;
  logic [2:0] alsu_A, alsu_B, alsu_opcode;
  logic       alsu_cin, alsu_serial_in, alsu_red_op_A, alsu_red_op_B;
  logic       alsu_bypass_A, alsu_bypass_B, alsu_direction;
  logic [5:0] alsu_out;
  logic       rsp_valid, rsp_ready, rsp_err;
  logic [5:0] rsp_data;
  logic [1:0] rsp_tag;

  int total = 0;
  int bad   = 0;
  int issued = 0;
  logic [8:0] got_q[$];

  alsu_cmd_seq #(.CMD_DEPTH(4), .RSP_DEPTH(4), .TAG_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_opcode(cmd_opcode), .cmd_ctrl(cmd_ctrl), .cmd_tag(cmd_tag),
    .alsu_A(alsu_A), .alsu_B(alsu_B), .alsu_opcode(alsu_opcode),
    .alsu_cin(alsu_cin), .alsu_serial_in(alsu_serial_in),
    .alsu_red_op_A(alsu_red_op_A), .alsu_red_op_B(alsu_red_op_B),
    .alsu_bypass_A(alsu_bypass_A), .alsu_bypass_B(alsu_bypass_B),
    .alsu_direction(alsu_direction), .alsu_out(alsu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---- behavioural ALSU ----
  logic [2:0] m_a, m_b, m_op;
  logic       m_cin, m_si, m_ra, m_rb, m_ba, m_bb, m_dir;

  function automatic logic [5:0] alsu_f(input logic [2:0] a, b, op,
                                        input logic cin, si, ra, rb, ba, bb, dir,
                                        input logic [5:0] prev);
    logic signed [5:0] sa, sb;
    sa = {{3{a[2]}}, a};
    sb = {{3{b[2]}}, b};
    if (ba) return {3'b0, a};
    if (bb) return {3'b0, b};
    if (((ra | rb) && (op[1] | op[2])) || (op[1] && op[2])) return 6'd0;
    case (op)
      3'd0: return ra ? {5'b0, |a} : rb ? {5'b0, |b} : {3'b0, a | b};
      3'd1: return ra ? {5'b0, ^a} : rb ? {5'b0, ^b} : {3'b0, a ^ b};
      3'd2: return sa + sb + {5'b0, cin};
      3'd3: return sa * sb;
      3'd4: return dir ? {prev[4:0], si} : {si, prev[5:1]};
      3'd5: return dir ? {prev[4:0], prev[5]} : {prev[0], prev[5:1]};
      default: return 6'd0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {m_a, m_b, m_op} <= '0;
      {m_cin, m_si, m_ra, m_rb, m_ba, m_bb, m_dir} <= '0;
      alsu_out <= '0;
    end else begin
      m_a <= alsu_A; m_b <= alsu_B; m_op <= alsu_opcode;
      m_cin <= alsu_cin; m_si <= alsu_serial_in; m_ra <= alsu_red_op_A; m_rb <= alsu_red_op_B;
      m_ba <= alsu_bypass_A; m_bb <= alsu_bypass_B; m_dir <= alsu_direction;
      alsu_out <= alsu_f(m_a, m_b, m_op, m_cin, m_si, m_ra, m_rb, m_ba, m_bb, m_dir, alsu_out);
    end
  end

  // response collector and issue monitor
  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) got_q.push_back({rsp_data, rsp_tag, rsp_err});
    if (alsu_bypass_A) issued++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] a, b, op, input logic [6:0] ctrl, input logic [1:0] tag);
    bit done = 1'b0;
    cmd_a = a; cmd_b = b; cmd_opcode = op; cmd_ctrl = ctrl; cmd_tag = tag; cmd_valid = 1'b1;
    for (int g = 0; g < 40 && !done; g++) begin
      done = cmd_ready;
      tick();
    end
    cmd_valid = 1'b0;
    if (!done) chk("push_timeout", 0, 1);
  endtask

  task automatic wait_rsp(input int n, input string name);
    int g = 0;
    while (got_q.size() < n && g < 60) begin
      tick();
      g++;
    end
    chk(name, got_q.size(), n);
  endtask

  task automatic chk_reset_outputs(input string tagname);
    chk({tagname, "_cmd_ready"}, cmd_ready, 0);
    chk({tagname, "_alsu_abop"}, {alsu_A, alsu_B, alsu_opcode}, 0);
    chk({tagname, "_alsu_ctrl"}, {alsu_bypass_B, alsu_bypass_A, alsu_red_op_B, alsu_red_op_A,
                                  alsu_direction, alsu_serial_in, alsu_cin}, 0);
    chk({tagname, "_rsp_valid"}, rsp_valid, 0);
    chk({tagname, "_rsp_fields"}, {rsp_data, rsp_tag, rsp_err}, 0);
  endtask

  typedef struct {
    logic [2:0] a, b, op;
    logic [6:0] ctrl;
    logic [1:0] tag;
    logic [5:0] exp_data;
    logic       exp_err;
  } vec_t;

  vec_t vt[11];

  initial begin
    int lat;
    int k, base;
    vt[0]  = '{3'd3, 3'd5, 3'd0, 7'h00, 2'd1, 6'd7, 1'b0};  // OR
    vt[1]  = '{3'd3, 3'd2, 3'd2, 7'h01, 2'd2, 6'd6, 1'b0};  // add with carry
    vt[2]  = '{3'd3, 3'd2, 3'd6, 7'h00, 2'd3, 6'd0, 1'b1};  // invalid opcode
    vt[3]  = '{3'd3, 3'd0, 3'd6, 7'h20, 2'd0, 6'd3, 1'b0};  // bypass_A masks invalid
    vt[4]  = '{3'd3, 3'd1, 3'd1, 7'h00, 2'd1, 6'd2, 1'b0};  // XOR
    vt[5]  = '{3'd1, 3'd1, 3'd2, 7'h08, 2'd2, 6'd0, 1'b1};  // reduction on add
    vt[6]  = '{3'd4, 3'd0, 3'd0, 7'h08, 2'd3, 6'd1, 1'b0};  // OR-reduce A
    vt[7]  = '{3'd2, 3'd3, 3'd3, 7'h00, 2'd0, 6'd6, 1'b0};  // multiply
    vt[8]  = '{3'd0, 3'd2, 3'd7, 7'h40, 2'd1, 6'd2, 1'b0};  // bypass_B masks invalid
    vt[9]  = '{3'd0, 3'd0, 3'd4, 7'h06, 2'd2, 6'd1, 1'b0};  // isolated shift left
    vt[10] = '{3'd0, 3'd0, 3'd5, 7'h06, 2'd3, 6'd0, 1'b0};  // isolated rotate

    rst_n = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b1;
    cmd_a = '0; cmd_b = '0; cmd_opcode = '0; cmd_ctrl = '0; cmd_tag = '0;
    #1 rst_n = 1'b0;
    #2 chk_reset_outputs("por");
    tick(); tick();
    rst_n = 1'b1;
    chk("ready_before_first_clk", cmd_ready, 0);
    tick();
    chk("ready_after_first_clk", cmd_ready, 1);

    // single isolated commands: pins one cycle after accept, response four cycles after
    for (int i = 0; i < 11; i++) begin
      cmd_a = vt[i].a; cmd_b = vt[i].b; cmd_opcode = vt[i].op;
      cmd_ctrl = vt[i].ctrl; cmd_tag = vt[i].tag; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      lat = 0;
      for (int n = 1; n <= 8 && lat == 0; n++) begin
        tick();
        if (n == 1) begin
          chk($sformatf("v%0d_pin_op", i), alsu_opcode, vt[i].op);
          chk($sformatf("v%0d_pin_a", i), alsu_A, vt[i].a);
        end
        if (rsp_valid) begin
          lat = n;
          chk($sformatf("v%0d_data", i), rsp_data, vt[i].exp_data);
          chk($sformatf("v%0d_tag", i), rsp_tag, vt[i].tag);
          chk($sformatf("v%0d_err", i), rsp_err, vt[i].exp_err);
        end
      end
      chk($sformatf("v%0d_latency", i), lat, 4);
      tick(); tick();
    end

    // chained shifts back-to-back: 1, 3, 7
    got_q.delete();
    for (int i = 0; i < 3; i++) push(3'd0, 3'd0, 3'd4, 7'h06, 2'(i));
    wait_rsp(3, "chain_count");
    for (int i = 0; i < 3 && i < got_q.size(); i++)
      chk($sformatf("chain%0d_data", i), got_q[i][8:3], (6'd1 << (i + 1)) - 6'd1);

    // same shifts separated by idle cycles: 1, 1, 1
    tick(); tick(); tick();
    got_q.delete();
    for (int i = 0; i < 3; i++) begin
      push(3'd0, 3'd0, 3'd4, 7'h06, 2'(i));
      tick();
    end
    wait_rsp(3, "gap_count");
    for (int i = 0; i < 3 && i < got_q.size(); i++)
      chk($sformatf("gap%0d_data", i), got_q[i][8:3], 1);

    // backpressure: 10 bypass_A commands, data = index, tag = index mod 4
    tick(); tick(); tick(); tick();
    got_q.delete();
    base = issued;
    rsp_ready = 1'b0;
    k = 0;
    for (int cyc = 0; cyc < 60 && k < 10; cyc++) begin
      logic rdy;
      if (cyc == 16) rsp_ready = 1'b1;
      cmd_a = 3'(k); cmd_b = 3'd0; cmd_opcode = 3'd0; cmd_ctrl = 7'h20; cmd_tag = 2'(k);
      cmd_valid = 1'b1;
      rdy = cmd_ready;
      tick();
      if (rdy) k++;
      if (cyc == 15) begin
        chk("bp_accepted", k, 8);
        chk("bp_issued", issued - base, 4);
        chk("bp_cmd_ready_low", cmd_ready, 0);
        chk("bp_rsp_held", {rsp_valid, rsp_tag}, {1'b1, 2'd0});
      end
    end
    cmd_valid = 1'b0;
    chk("bp_all_pushed", k, 10);
    wait_rsp(10, "bp_rsp_count");
    tick(); tick(); tick(); tick(); tick(); tick();
    chk("bp_no_duplicates", got_q.size(), 10);
    for (int i = 0; i < 10 && i < got_q.size(); i++)
      chk($sformatf("bp%0d_rsp", i), got_q[i], {6'(i % 8), 2'(i), 1'b0});

    // reset with work in flight and buffered
    tick(); tick();
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(3'(i + 1), 3'd0, 3'd0, 7'h01, 2'(i + 1));
    chk("pre_reset_rsp_valid", rsp_valid, 1);
    chk("pre_reset_pins_busy", alsu_A != 3'd0, 1);
    rst_n = 1'b0;
    #1 chk_reset_outputs("midrst");
    tick();
    chk("in_reset_ready", cmd_ready, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset_ready", cmd_ready, 1);
    rsp_ready = 1'b1;
    got_q.delete();
    push(3'd1, 3'd2, 3'd0, 7'h00, 2'd2);
    tick(); tick(); tick();
    chk("post_reset_early", rsp_valid, 0);
    tick();
    chk("post_reset_rsp", {rsp_valid, rsp_data, rsp_tag, rsp_err}, {1'b1, 6'd3, 2'd2, 1'b0});
    tick(); tick(); tick(); tick(); tick();
    chk("post_reset_no_stale", got_q.size(), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
